// File: rtl/cl_word_cache.sv
// cl_word_cache: single-line write-back cache between a 32-bit CPU word port and cache-line DMA channels.
module cl_word_cache #(
  parameter int WORD_WIDTH = 32,
  parameter int CL_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 43
) (
  input  logic clk,
  input  logic rst,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic req_valid,
  input  logic req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic req_ready,
  output logic rsp_valid,
  output logic [WORD_WIDTH-1:0] rsp_rdata,
  input  logic flush,
  output logic flush_done,
  output logic [ADDR_WIDTH-1:0] dma_rd_addr,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr,
  output logic [SIZE_WIDTH-1:0] dma_rd_size,
  output logic [SIZE_WIDTH-1:0] dma_wr_size,
  output logic dma_rd_go,
  output logic dma_wr_go,
  output logic dma_rd_en,
  input  logic dma_empty,
  input  logic [CL_WIDTH-1:0] dma_rd_data,
  input  logic dma_rd_done,
  output logic dma_wr_en,
  input  logic dma_full,
  output logic [CL_WIDTH-1:0] dma_wr_data,
  input  logic dma_wr_done
);
  localparam int WORDS = CL_WIDTH / WORD_WIDTH;
  localparam int OFF = $clog2(CL_WIDTH / 8);
  localparam int IW = $clog2(WORDS);
  localparam int TW = ADDR_WIDTH - OFF;
  typedef enum logic [3:0] {IDLE, RESP, FL_DONE, WB_GO, WB_DATA, WB_WAIT, FILL_GO, FILL_DATA, FILL_WAIT} state_t;
  state_t state_q, state_d;
  logic valid_q, valid_d, dirty_q, dirty_d, we_q, we_d, fl_q, fl_d;
  logic [TW-1:0] tag_q, tag_d, rtag_q, rtag_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [CL_WIDTH-1:0] line_q, line_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [TW-1:0] req_tag;
  logic hit, evict, unused;
  logic [ADDR_WIDTH-1:0] old_addr, new_addr;
  assign req_tag = req_addr[ADDR_WIDTH-1:OFF];
  assign hit = valid_q && req_tag == tag_q;
  assign evict = valid_q && dirty_q;
  assign unused = ^req_addr[OFF-IW-1:0];
  assign old_addr = base_addr + {tag_q, {OFF{1'b0}}};
  assign new_addr = base_addr + {(state_q == IDLE ? req_tag : rtag_q), {OFF{1'b0}}};
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    we_d = we_q;
    fl_d = fl_q;
    tag_d = tag_q;
    rtag_d = rtag_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    line_d = line_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rtag_d = req_tag;
          idx_d = req_addr[OFF-1:OFF-IW];
          we_d = req_we;
          wdata_d = req_wdata;
          fl_d = 1'b0;
          state_d = hit ? RESP : evict ? WB_GO : FILL_GO;
          wr_addr_d = (!hit && evict) ? old_addr : wr_addr_q;
          rd_addr_d = (!hit && !evict) ? new_addr : rd_addr_q;
        end else if (flush) begin
          fl_d = 1'b1;
          state_d = evict ? WB_GO : FL_DONE;
          wr_addr_d = evict ? old_addr : wr_addr_q;
        end
      end
      WB_GO: state_d = WB_DATA;
      WB_DATA: state_d = dma_full ? WB_DATA : WB_WAIT;
      WB_WAIT: begin
        if (dma_wr_done) begin
          dirty_d = 1'b0;
          state_d = fl_q ? FL_DONE : FILL_GO;
          rd_addr_d = fl_q ? rd_addr_q : new_addr;
        end
      end
      FILL_GO: state_d = FILL_DATA;
      FILL_DATA: begin
        line_d = dma_empty ? line_q : dma_rd_data;
        state_d = dma_empty ? FILL_DATA : FILL_WAIT;
      end
      FILL_WAIT: begin
        valid_d = valid_q || dma_rd_done;
        tag_d = dma_rd_done ? rtag_q : tag_q;
        state_d = dma_rd_done ? RESP : FILL_WAIT;
      end
      RESP: begin
        // Misses land here too, so a write miss allocates then merges the word.
        if (we_q) begin
          line_d[idx_q*WORD_WIDTH +: WORD_WIDTH] = wdata_q;
          dirty_d = 1'b1;
        end
        state_d = IDLE;
      end
      FL_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      we_q <= 1'b0;
      fl_q <= 1'b0;
      tag_q <= '0;
      rtag_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      line_q <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      we_q <= we_d;
      fl_q <= fl_d;
      tag_q <= tag_d;
      rtag_q <= rtag_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      line_q <= line_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
    end
  end
  // Pulses are gated by rst so they drop within the reset cycle itself.
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP && !rst;
  assign rsp_rdata = (rsp_valid && !we_q) ? line_q[idx_q*WORD_WIDTH +: WORD_WIDTH] : '0;
  assign flush_done = state_q == FL_DONE && !rst;
  assign dma_wr_go = state_q == WB_GO && !rst;
  assign dma_rd_go = state_q == FILL_GO && !rst;
  assign dma_wr_en = state_q == WB_DATA && !dma_full && !rst;
  assign dma_rd_en = state_q == FILL_DATA && !dma_empty && !rst;
  assign dma_rd_addr = rd_addr_q;
  assign dma_wr_addr = wr_addr_q;
  assign dma_rd_size = SIZE_WIDTH'(1);
  assign dma_wr_size = SIZE_WIDTH'(1);
  assign dma_wr_data = line_q;
endmodule

// File: tb/tb_cl_word_cache.sv
// tb_cl_word_cache: directed checks of cl_word_cache against a small DMA responder.
module tb_cl_word_cache;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [63:0] base_addr;
  logic req_valid, req_we, req_ready, rsp_valid, flush, flush_done;
  logic [63:0] req_addr;
  logic [31:0] req_wdata, rsp_rdata;
  logic [63:0] dma_rd_addr, dma_wr_addr;
  logic [42:0] dma_rd_size, dma_wr_size;
  logic dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en;
  logic dma_empty = 1, dma_full = 0, dma_rd_done = 0, dma_wr_done = 0;
  logic [511:0] dma_rd_data, dma_wr_data, fill_line;
  assign dma_rd_data = fill_line;
  cl_word_cache dut (
    .clk(clk), .rst(rst), .base_addr(base_addr),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .flush(flush), .flush_done(flush_done),
    .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr),
    .dma_rd_size(dma_rd_size), .dma_wr_size(dma_wr_size),
    .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go), .dma_rd_en(dma_rd_en),
    .dma_empty(dma_empty), .dma_rd_data(dma_rd_data), .dma_rd_done(dma_rd_done),
    .dma_wr_en(dma_wr_en), .dma_full(dma_full), .dma_wr_data(dma_wr_data), .dma_wr_done(dma_wr_done)
  );
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [511:0] mk_line(input logic [31:0] b);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = b + k;
    return r;
  endfunction
  int cyc = 0, rd_go_cnt = 0, wr_go_cnt = 0, rd_en_cnt = 0, wr_en_cnt = 0, stall_viol = 0, rdy_bad = 0;
  int rd_go_cyc = 0, wr_en_cyc = 0;
  logic m_rd_go = 0, m_wr_go = 0, m_rd_en = 0, m_wr_en = 0;
  logic [63:0] last_rd_addr = 0, last_wr_addr = 0;
  logic [42:0] last_rd_size = 0;
  logic [511:0] last_wr_data = 0;
  always @(negedge clk) begin
    cyc++;
    m_rd_go = dma_rd_go;
    m_wr_go = dma_wr_go;
    m_rd_en = dma_rd_en;
    m_wr_en = dma_wr_en;
    if (dma_rd_go) begin rd_go_cnt++; last_rd_addr = dma_rd_addr; last_rd_size = dma_rd_size; rd_go_cyc = cyc; end
    if (dma_wr_go) begin wr_go_cnt++; last_wr_addr = dma_wr_addr; end
    if (dma_rd_en) rd_en_cnt++;
    if (dma_wr_en) begin wr_en_cnt++; last_wr_data = dma_wr_data; wr_en_cyc = cyc; end
    if ((dma_wr_en && dma_full) || (dma_rd_en && dma_empty)) stall_viol++;
  end
  // DMA responder: stalls for a programmed number of cycles, done rises after the data beat.
  int rd_stall = 0, wr_stall = 0, rd_cnt = 0, wr_cnt = 0;
  logic rd_busy = 0, wr_busy = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      dma_empty = 1; dma_full = 0; dma_rd_done = 0; dma_wr_done = 0; rd_busy = 0; wr_busy = 0;
    end else begin
      if (m_rd_go) begin dma_rd_done = 0; rd_cnt = rd_stall; rd_busy = 1; end
      else if (m_rd_en) begin dma_empty = 1; dma_rd_done = 1; rd_busy = 0; end
      else if (rd_busy) begin if (rd_cnt == 0) dma_empty = 0; else rd_cnt--; end
      if (m_wr_go) begin dma_wr_done = 0; wr_cnt = wr_stall; dma_full = (wr_stall != 0); wr_busy = 1; end
      else if (m_wr_en) begin dma_wr_done = 1; wr_busy = 0; end
      else if (wr_busy && wr_cnt != 0) begin wr_cnt--; if (wr_cnt == 0) dma_full = 0; end
    end
  end
  task automatic do_req(input logic we, input logic [63:0] a, input logic [31:0] d, output logic [31:0] rd, output int lat);
    logic got = 0;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    @(posedge clk); #2;
    req_valid = 0;
    lat = 0; rd = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (req_ready) rdy_bad++;
      if (rsp_valid) begin got = 1; rd = rsp_rdata; end
    end
    @(posedge clk); #2;
  endtask
  task automatic do_flush(output int lat);
    logic got = 0;
    flush = 1;
    @(posedge clk); #2;
    flush = 0;
    lat = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (req_ready) rdy_bad++;
      if (flush_done) got = 1;
    end
    @(posedge clk); #2;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] rd;
    logic [511:0] e;
    int lat, g;
    base_addr = 64'h1000; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; flush = 0;
    fill_line = mk_line(32'hA0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_pulses", {rsp_valid, flush_done, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}, 0);
    chk("rst_addr", {dma_rd_addr, dma_wr_addr, rsp_rdata}, 0);
    chk("rst_size", {dma_rd_size, dma_wr_size}, {43'd1, 43'd1});
    @(posedge clk); #2;
    do_req(0, 64'h48, 0, rd, lat);
    chk("miss_rdata", rd, 32'hA2);
    chk("miss_lat", lat, 5);
    chk("miss_rd_go", rd_go_cnt, 1);
    chk("miss_rd_addr", last_rd_addr, 64'h1040);
    chk("miss_rd_size", last_rd_size, 1);
    chk("miss_no_wb", wr_go_cnt, 0);
    do_req(0, 64'h4C, 0, rd, lat);
    chk("hit_rdata", rd, 32'hA3);
    chk("hit_lat", lat, 1);
    chk("hit_no_go", rd_go_cnt, 1);
    do_req(1, 64'h44, 32'hDEAD, rd, lat);
    chk("whit_lat", lat, 1);
    chk("whit_rdata0", rd, 0);
    fill_line = mk_line(32'hB0);
    do_req(0, 64'h80, 0, rd, lat);
    e = mk_line(32'hA0);
    e[32 +: 32] = 32'hDEAD;
    chk("evict_rdata", rd, 32'hB0);
    chk("evict_lat", lat, 8);
    chk("evict_wr_go", wr_go_cnt, 1);
    chk("evict_wr_addr", last_wr_addr, 64'h1040);
    chk("evict_wr_en", wr_en_cnt, 1);
    chk("evict_wr_data", last_wr_data, e);
    chk("evict_rd_go", rd_go_cnt, 2);
    chk("evict_rd_addr", last_rd_addr, 64'h1080);
    chk("evict_order", wr_en_cyc < rd_go_cyc, 1);
    do_flush(lat);
    chk("flush_clean_lat", lat, 1);
    chk("flush_clean_nowb", wr_go_cnt, 1);
    do_req(1, 64'h84, 32'h1234, rd, lat);
    chk("w84_lat", lat, 1);
    do_flush(lat);
    e = mk_line(32'hB0);
    e[32 +: 32] = 32'h1234;
    chk("flush_dirty_lat", lat, 4);
    chk("flush_dirty_wr_go", wr_go_cnt, 2);
    chk("flush_dirty_addr", last_wr_addr, 64'h1080);
    chk("flush_dirty_data", last_wr_data, e);
    do_flush(lat);
    chk("flush_again_lat", lat, 1);
    chk("flush_again_nowb", wr_go_cnt, 2);
    do_req(0, 64'h84, 0, rd, lat);
    chk("after_flush_hit", {lat[7:0], rd}, {8'd1, 32'h1234});
    do_req(1, 64'h88, 32'h55, rd, lat);
    wr_stall = 20; rd_stall = 15;
    fill_line = mk_line(32'hC0);
    do_req(0, 64'h1C8, 0, rd, lat);
    e[64 +: 32] = 32'h55;
    chk("bp_rdata", rd, 32'hC2);
    chk("bp_lat", lat, 43);
    chk("bp_wr_data", last_wr_data, e);
    chk("bp_rd_addr", last_rd_addr, 64'h11C0);
    chk("bp_en_counts", {wr_en_cnt[7:0], rd_en_cnt[7:0]}, {8'd3, 8'd3});
    chk("bp_stall_viol", stall_viol, 0);
    wr_stall = 0; rd_stall = 5;
    req_valid = 1; req_we = 0; req_addr = 64'h200;
    @(posedge clk); #2;
    req_valid = 0;
    @(posedge clk); #2;
    rst = 1;
    @(negedge clk);
    chk("midrst_pulses", {dma_rd_go, dma_rd_en, dma_wr_go, dma_wr_en, rsp_valid}, 0);
    @(posedge clk); #2;
    rst = 0;
    @(negedge clk);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_addr", dma_rd_addr, 0);
    @(posedge clk); #2;
    rd_stall = 0;
    g = rd_go_cnt;
    do_req(0, 64'h1C8, 0, rd, lat);
    chk("midrst_invalid", {lat[7:0], rd}, {8'd5, 32'hC2});
    chk("midrst_new_go", rd_go_cnt, g + 1);
    fill_line = mk_line(32'hD0);
    do_req(0, 64'h200, 0, rd, lat);
    chk("reread_200", {lat[7:0], rd}, {8'd5, 32'hD0});
    chk("reread_go", rd_go_cnt, g + 2);
    chk("reread_nowb", wr_go_cnt, 3);
    base_addr = 64'hFFFF_FFFF_FFFF_FFC0;
    fill_line = mk_line(32'hE0);
    do_req(0, 64'h84, 0, rd, lat);
    chk("wrap_addr", last_rd_addr, 64'h40);
    chk("wrap_rdata", rd, 32'hE1);
    chk("ready_low_busy", rdy_bad, 0);
    chk("stall_viol_end", stall_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cl_word_cache.md
Name: cl_word_cache

Overview:
- Single-line, write-back cache bridging the 32-bit word-oriented CPU memory port and the cache-line DMA read/write channels.
- CPU issues word reads/writes at 64-bit byte addresses. The block serves hits from a one-line buffer, and on a miss writes back the dirty line and then fills the new line through the DMA.
- Sits directly between the CPU memory-request port and the DMA peripheral interface in the AFU.

Parameters:
- WORD_WIDTH, 32, CPU data word width in bits.
- CL_WIDTH, 512, cache line width in bits (WORDS = CL_WIDTH/WORD_WIDTH = 16).
- ADDR_WIDTH, 64, virtual byte address width.
- SIZE_WIDTH, 43, width of DMA size fields.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- base_addr  in  ADDR_WIDTH  byte offset added to every DMA address (from memory map)
- req_valid  in  1  CPU request present
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  CPU byte address; bits[1:0] ignored
- req_wdata  in  WORD_WIDTH  write data
- req_ready  out  1  block can accept a request or flush
- rsp_valid  out  1  one-cycle pulse: request complete
- rsp_rdata  out  WORD_WIDTH  read data, valid with rsp_valid
- flush  in  1  write back the line if it is dirty
- flush_done  out  1  one-cycle pulse: flush complete
- dma_rd_addr, dma_wr_addr  out  ADDR_WIDTH  DMA line byte addresses
- dma_rd_size, dma_wr_size  out  SIZE_WIDTH  constant 1
- dma_rd_go, dma_wr_go  out  1  one-cycle start pulses
- dma_rd_en  out  1  pop read data
- dma_empty  in  1  read data not available
- dma_rd_data  in  CL_WIDTH  read line (first-word-fall-through)
- dma_rd_done  in  1  read transfer complete (level)
- dma_wr_en  out  1  push write data
- dma_full  in  1  write channel cannot accept data
- dma_wr_data  out  CL_WIDTH  line buffer contents
- dma_wr_done  in  1  write transfer complete (level)

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - Reset is synchronous and active-high: rst.
  - On reset, all outputs are 0 except req_ready=1 and the size outputs, which are constant 1. valid=0, dirty=0, state=IDLE.
- Address fields:
  - tag = req_addr[ADDR_WIDTH-1:6], word index = req_addr[5:2].
  - Word i occupies line bits [32i+31:32i].
  - DMA address = base_addr + {tag, 6'b0}, modulo 2^64 (wrap, no error).
- Request acceptance:
  - req_ready=1 only in IDLE. A request is accepted when req_valid && req_ready.
  - req_valid has priority over flush when both are asserted.
  - Accepted address, write data and we are registered.
- Hit (valid && tag match):
  - rsp_valid pulses in the cycle after acceptance (latency 1); req_ready is 0 in that cycle.
  - Read: rsp_rdata = buffered word.
  - Write: the word is updated and dirty=1. rsp_rdata is don't-care, driven 0.
- Miss: states IDLE -> [WB_GO -> WB_DATA -> WB_WAIT] (only if valid && dirty) -> FILL_GO -> FILL_DATA -> FILL_WAIT -> RESP -> IDLE.
  - WB_GO: dma_wr_go=1 for one cycle, dma_wr_addr = old line address.
  - WB_DATA: dma_wr_en=1 for exactly one cycle, in the first cycle dma_full=0. dma_wr_data = line buffer.
  - WB_WAIT: wait for dma_wr_done=1, then dirty=0.
  - FILL_GO: dma_rd_go=1 for one cycle, dma_rd_addr = new line address.
  - FILL_DATA: in the first cycle dma_empty=0, dma_rd_en=1 for one cycle and dma_rd_data is captured in the same cycle.
  - FILL_WAIT: wait for dma_rd_done=1. valid=1, tag updated.
  - RESP: the request is applied to the buffer exactly as on a hit (write-allocate, fetch-on-write). rsp_valid=1.
- Done sampling: dma_*_done is ignored in the go cycle and is sampled from the cycle after the go cycle onward.
- Address stability: DMA addresses are held stable from the go cycle until the corresponding done is observed.
- Flush (accepted in IDLE with req_valid=0):
  - Clean or invalid line: flush_done pulses the next cycle and no DMA activity occurs.
  - Dirty line: WB_GO/WB_DATA/WB_WAIT, then flush_done pulses one cycle after dma_wr_done is seen. Line stays valid with dirty=0.
- Backpressure:
  - dma_full or dma_empty held high stalls indefinitely with wr_en/rd_en=0.
  - No timeout.
  - req_ready stays 0 throughout.
- Reset mid-operation:
  - Returns to IDLE; go/en drop in the same reset cycle.
  - valid and dirty are cleared, so any dirty data is lost.
  - The DMA shares rst and is reset alongside.
- Outstanding operations: at most one request or flush at a time. No DMA pulse overlaps another.

Test Plan:
- Reset: assert rst 2 cycles -> all DMA outputs 0, req_ready=1, rsp_valid=0, flush_done=0.
- Read miss and hit:
  - base=0x1000, read 0x48 -> dma_rd_go with rd_addr=0x1040, size=1.
  - Supply line with word k=0xA0+k -> rsp_rdata=0xA2.
  - Then read 0x4C -> rsp_valid next cycle, 0xA3, no rd_go.
- Dirty eviction:
  - After the line above, write 0x44 <- 0xDEAD (hit, 1-cycle rsp).
  - Read 0x80 -> wr_go at 0x1040 with word1=0xDEAD and the other words 0xA0+k, wr_en once, then rd_go at 0x1080.
- Flush:
  - Clean line -> flush_done next cycle, no wr_go.
  - Dirty line -> wr_go at the line address; flush_done one cycle after wr_done; a second flush is then clean.
- Backpressure: hold dma_full=1 for 20 cycles during writeback and dma_empty=1 for 15 cycles during fill -> no en pulses while stalled, req_ready=0, correct rsp afterwards.
- Reset mid-fill: assert rst in FILL_DATA -> outputs zero. A re-read of the same address issues a new rd_go (line invalid).
